// File: rtl/fpu_addsub_pipe_param_if.sv
// rtl/fpu_addsub_pipe_param_if.sv - request/response bundle for the floating-point add/sub unit
// Purpose: groups the operand request and result response of fpu_addsub_pipe_param.
// Ports (signals):
//   start       request strobe, sampled by the unit only while idle
//   op_sub      0 = A+B, 1 = A-B
//   Op_A_in     operand A {sign, exp, mant}
//   Op_B_in     operand B {sign, exp, mant}
//   busy        operation in flight
//   done        one-cycle result strobe
//   data_out    result word, held until the next done
//   status_out  0 overflow, 1 underflow, 2 exact, 3 inexact
// master: requester side; slave: the arithmetic unit.
interface fpu_addsub_pipe_param_if #(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 21
);
  localparam int W = 1 + EXP_W + MANT_W;

  logic         start;
  logic         op_sub;
  logic [W-1:0] Op_A_in;
  logic [W-1:0] Op_B_in;
  logic         busy;
  logic         done;
  logic [W-1:0] data_out;
  logic [1:0]   status_out;

  modport master (
    output start, op_sub, Op_A_in, Op_B_in,
    input  busy, done, data_out, status_out
  );

  modport slave (
    input  start, op_sub, Op_A_in, Op_B_in,
    output busy, done, data_out, status_out
  );
endinterface

// File: rtl/fpu_addsub_pipe_param.sv
// rtl/fpu_addsub_pipe_param.sv - parametrised multi-cycle floating-point add/subtract unit
// Purpose: adds or subtracts two {sign, exp, mant} operands with round-to-nearest-even,
// one operation in flight, start/busy/done handshake.
// Ports:
//   clock_100Khz  system clock, rising edge
//   reset         asynchronous active-low reset
//   bus           fpu_addsub_pipe_param_if.slave (start, op_sub, Op_A_in, Op_B_in in;
//                 busy, done, data_out, status_out out)
module fpu_addsub_pipe_param #(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 21
) (
  input  logic                   clock_100Khz,
  input  logic                   reset,
  fpu_addsub_pipe_param_if.slave bus
);
  localparam int W  = 1 + EXP_W + MANT_W;
  // Working magnitude: {carry, hidden, mant, guard, round, sticky}
  localparam int N  = MANT_W + 5;
  localparam int XW = EXP_W + 2;

  localparam logic [1:0] ST_OVERFLOW  = 2'd0;
  localparam logic [1:0] ST_UNDERFLOW = 2'd1;
  localparam logic [1:0] ST_EXACT     = 2'd2;
  localparam logic [1:0] ST_INEXACT   = 2'd3;

  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((2 ** EXP_W) - 1);

  typedef enum logic [2:0] {
    IDLE, ALIGN, OPERATE, NORMALIZE, ROUND, WRITEBACK
  } state_t;

  state_t state, state_nx;

  logic                   sign_r;
  logic                   diff_sign_r;
  logic signed [XW-1:0]   exp_r;
  logic [EXP_W-1:0]       shift_r;
  logic [N-1:0]           acc;
  logic [N-1:0]           s_vec;
  logic [MANT_W-1:0]      res_mant;
  logic signed [XW-1:0]   res_exp;
  logic                   inexact_r;
  logic                   zero_r;
  logic                   busy_r;
  logic                   done_r;
  logic [W-1:0]           data_r;
  logic [1:0]             status_r;

  // Operand unpack and magnitude ordering
  logic [EXP_W-1:0] exp_a, exp_b;
  logic             sign_b_eff;
  logic             a_ge_b;
  logic [N-1:0]     vec_a, vec_b;

  always_comb begin
    exp_a      = bus.Op_A_in[W-2:MANT_W];
    exp_b      = bus.Op_B_in[W-2:MANT_W];
    sign_b_eff = bus.Op_B_in[W-1] ^ bus.op_sub;
    a_ge_b     = bus.Op_A_in[W-2:0] >= bus.Op_B_in[W-2:0];
    vec_a      = '0;
    vec_b      = '0;
    // exp == 0 encodes zero: the mantissa field is ignored entirely
    if (exp_a != '0) vec_a = {2'b01, bus.Op_A_in[MANT_W-1:0], 3'b000};
    if (exp_b != '0) vec_b = {2'b01, bus.Op_B_in[MANT_W-1:0], 3'b000};
  end

  // Alignment shifter: bits falling off the bottom collapse into sticky
  logic [2*N-1:0] align_ext;
  logic [N-1:0]   s_aligned;

  always_comb begin
    align_ext = {s_vec, {N{1'b0}}} >> shift_r;
    if (32'(shift_r) >= MANT_W + 3)
      s_aligned = {{(N-1){1'b0}}, |s_vec};
    else
      s_aligned = align_ext[2*N-1:N] | {{(N-1){1'b0}}, |align_ext[N-1:0]};
  end

  // Normalisation decisions
  logic need_right, need_left;

  always_comb begin
    need_right = acc[N-1];
    need_left  = !acc[N-1] && !acc[N-2] && (acc != '0);
  end

  // Round to nearest even on the normalised magnitude
  logic              rnd_inc;
  logic [MANT_W+1:0] rnd_sum;

  always_comb begin
    rnd_inc = acc[2] & (acc[1] | acc[0] | acc[3]);
    rnd_sum = {1'b0, acc[N-2:3]} + {{(MANT_W+1){1'b0}}, rnd_inc};
  end

  // Result packing with special-case priority
  logic [W-1:0] wb_data;
  logic [1:0]   wb_status;

  always_comb begin
    wb_data   = {sign_r, res_exp[EXP_W-1:0], res_mant};
    wb_status = inexact_r ? ST_INEXACT : ST_EXACT;
    if (zero_r) begin
      // Exact cancellation always yields +0
      wb_data   = '0;
      wb_status = ST_EXACT;
    end else if (res_exp >= EXP_MAX) begin
      wb_data   = {sign_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      wb_status = ST_OVERFLOW;
    end else if (res_exp <= EXP_ZERO) begin
      wb_data   = {sign_r, {(EXP_W+MANT_W){1'b0}}};
      wb_status = ST_UNDERFLOW;
    end
  end

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (bus.start) state_nx = ALIGN;
      ALIGN:     state_nx = OPERATE;
      OPERATE:   state_nx = NORMALIZE;
      NORMALIZE: if (!(need_right || need_left)) state_nx = ROUND;
      ROUND:     state_nx = WRITEBACK;
      WRITEBACK: state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      sign_r      <= 1'b0;
      diff_sign_r <= 1'b0;
      exp_r       <= '0;
      shift_r     <= '0;
      acc         <= '0;
      s_vec       <= '0;
      res_mant    <= '0;
      res_exp     <= '0;
      inexact_r   <= 1'b0;
      zero_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      data_r      <= '0;
      status_r    <= ST_EXACT;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_r      <= 1'b1;
            diff_sign_r <= bus.Op_A_in[W-1] ^ sign_b_eff;
            if (a_ge_b) begin
              sign_r  <= bus.Op_A_in[W-1];
              exp_r   <= {2'b00, exp_a};
              shift_r <= exp_a - exp_b;
              acc     <= vec_a;
              s_vec   <= vec_b;
            end else begin
              sign_r  <= sign_b_eff;
              exp_r   <= {2'b00, exp_b};
              shift_r <= exp_b - exp_a;
              acc     <= vec_b;
              s_vec   <= vec_a;
            end
          end
        end
        ALIGN: s_vec <= s_aligned;
        OPERATE: acc <= diff_sign_r ? (acc - s_vec) : (acc + s_vec);
        NORMALIZE: begin
          if (need_right) begin
            acc   <= {1'b0, acc[N-1:2], acc[1] | acc[0]};
            exp_r <= exp_r + EXP_ONE;
          end else if (need_left) begin
            acc   <= {acc[N-2:0], 1'b0};
            exp_r <= exp_r - EXP_ONE;
          end
        end
        ROUND: begin
          zero_r    <= (acc == '0);
          inexact_r <= acc[2] | acc[1] | acc[0];
          if (rnd_sum[MANT_W+1]) begin
            res_mant <= rnd_sum[MANT_W:1];
            res_exp  <= exp_r + EXP_ONE;
          end else begin
            res_mant <= rnd_sum[MANT_W-1:0];
            res_exp  <= exp_r;
          end
        end
        WRITEBACK: begin
          data_r   <= wb_data;
          status_r <= wb_status;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.data_out   = data_r;
  assign bus.status_out = status_r;
endmodule

// File: doc/fpu_addsub_pipe_param.md
Name: fpu_addsub_pipe_param

Overview:
- Parametrised floating-point add/subtract unit; next generation of the team's fixed 32-bit {sign, 10-bit exp, 21-bit mant} adder FSM.
- Additions over the previous generation:
  - configurable exponent and mantissa widths;
  - runtime add/subtract select;
  - start/busy/done handshake;
  - round-to-nearest-even using guard/round/sticky bits;
  - zero handling;
  - status derived from real rounding information.
- Sits between operand registers and the result bus, one operation in flight at a time.

Parameters:
- EXP_W, 10, exponent field width; bias = 2^(EXP_W-1)-1 (511 at default).
- MANT_W, 21, stored mantissa field width; hidden bit is implicit.
- W, 1+EXP_W+MANT_W, derived word width; not overridable.

Ports:
- clock_100Khz  in   1  system clock; all state changes on its rising edge.
- reset         in   1  asynchronous, active-low reset.
- start         in   1  request; sampled only in IDLE.
- op_sub        in   1  0 = A+B, 1 = A-B; captured with start.
- Op_A_in       in   W  operand A, format {sign, exp, mant}.
- Op_B_in       in   W  operand B, same format.
- busy          out  1  high from the cycle after start is accepted until done.
- done          out  1  one-cycle pulse; data_out and status_out are valid from this cycle.
- data_out      out  W  result; held until the next done.
- status_out    out  2  0 = OVERFLOW, 1 = UNDERFLOW, 2 = EXACT, 3 = INEXACT.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE, busy = 0, done = 0, data_out = 0, status_out = EXACT;
  - all internal registers cleared; the in-flight operation is discarded.
- Number format:
  - exp == 0 means zero (hidden bit 0, mantissa ignored); no denormals;
  - exp == all-ones is never produced except as the overflow result.
- FSM: IDLE -> ALIGN -> OPERATE -> NORMALIZE (1..n cycles) -> ROUND -> WRITEBACK -> IDLE.
- IDLE:
  - when start = 1, capture both operands and op_sub; B's effective sign = sign_B XOR op_sub;
  - order operands by magnitude ({exp, mant} compare) so the larger is L and the smaller is S;
  - result sign = sign of L;
  - start = 0 leaves state unchanged.
- ALIGN (1 cycle):
  - shift S's {hidden, mant, G, R, S} right by exp_L - exp_S; shifted-out bits OR into sticky;
  - if the shift is >= MANT_W+3, S becomes 0 and sticky = (S nonzero).
- OPERATE (1 cycle):
  - add magnitudes if the signs are equal, otherwise subtract S from L;
  - keep the carry-out; working exponent = exp_L.
- NORMALIZE:
  - on carry: shift right once, keep sticky, exp+1;
  - else if hidden bit is 0 and the result is nonzero: shift left once, exp-1;
  - one shift per cycle; leave for ROUND on the first cycle that needs no shift;
  - a zero magnitude goes directly to ROUND.
  - Let k = number of shift cycles; NORMALIZE occupies k+1 cycles.
- ROUND (1 cycle):
  - round to nearest even: increment when G & (R | S | lsb);
  - a mantissa overflow from rounding renormalises (exp+1);
  - inexact = G | R | S.
- WRITEBACK (1 cycle):
  - on the edge leaving this state, register data_out and status_out, pulse done, drop busy.
- Result priority:
  - zero magnitude -> data_out = all zeros (+0), status EXACT (exact cancellation gives +0);
  - final exp >= all-ones -> {sign, all-ones, 0}, status OVERFLOW;
  - final exp <= 0 -> {sign, 0, 0}, status UNDERFLOW;
  - otherwise status INEXACT if the inexact flag is set, else EXACT.
- Timing:
  - latency from the start-sampling edge to done high is 5+k edges; k <= MANT_W+1;
  - start while busy is ignored (no queueing);
  - start may be high in the same cycle done is high; it is not sampled until the state is IDLE.
- Arithmetic: internal datapath is MANT_W+5 bits (carry, hidden, mant, G, R) plus a sticky bit; exponent path is EXP_W+2 bits signed.

Test Plan (defaults, bias 511):
- 1.0+1.0 (0x3FE00000, 0x3FE00000, op_sub=0) -> data_out 0x40000000, EXACT; done exactly 6 edges after start (k=1); busy high throughout.
- 2.0+1.0 (0x40000000, 0x3FE00000) -> 0x40100000, EXACT; then 1.0-1.0 with op_sub=1 -> 0x00000000, EXACT.
- 1.5-0.5 via op_sub=1 (0x3FF00000, 0x3FC00000) -> 0x3FE00000, EXACT; 1.5+(-1.0) (0x3FF00000, 0xBFE00000) -> 0x3FC00000, EXACT, done at edge 6 (one left shift).
- 1.0+2^-23 (0x3FE00000, exp 488 mant 0 = 0x3D000000) -> 0x3FE00000, INEXACT (round bit only, tie not reached).
- Max+max (0x7FDFFFFF twice) -> 0x7FE00000, OVERFLOW; tiny-tiny near cancellation with exp 1 operands (0x003FFFFF - 0x00200000) -> underflow to sign-preserved zero, UNDERFLOW.
- Pulse start during busy with different operands -> ignored, first result unchanged; assert reset low mid-NORMALIZE -> outputs 0/EXACT immediately, busy=0; the next start completes normally.
